// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared types and default depths for the dispatch scheduler
//
// Holds the decoded micro-op layout, the FU type encodings and the default
// reservation-station / ROB depths used as parameter defaults by the top.
package sched_pkg;

    localparam int ALU_RS_DEPTH_DEF = 8;
    localparam int BR_RS_DEPTH_DEF  = 4;
    localparam int LSU_RS_DEPTH_DEF = 8;
    localparam int ROB_DEPTH_DEF    = 16;

    typedef enum logic [1:0] {
        FU_ALU = 2'b00,
        FU_BR  = 2'b01,
        FU_LSU = 2'b10,
        FU_ILL = 2'b11
    } fu_type_e;

    typedef struct packed {
        logic [8:0]  pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        fu_type_e    fu_type;
        logic        alu_src;
        logic        branch;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
    } uop_t;

endpackage

// File: rtl/credit_counter.sv
// rtl/credit_counter.sv - saturating free-slot credit counter
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (count resets to DEPTH)
//   consume     one credit taken this cycle (caller guarantees count != 0)
//   ret         one credit returned this cycle
//   reload      restore count to DEPTH, ignoring consume/ret
//   count       current free credits
//   nonzero     count != 0
//   overflow    pulse: a return arrived while already at DEPTH (dropped)
module credit_counter #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       consume,
    input  logic                       ret,
    input  logic                       reload,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       nonzero,
    output logic                       overflow
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d  = count_q;
        overflow = 1'b0;
        if (reload) begin
            count_d = FULL;
        end else if (consume && !ret) begin
            count_d = count_q - 1'b1;
        end else if (ret && !consume) begin
            // A surplus return is a bookkeeping bug upstream; hold at full.
            if (count_q == FULL) begin
                overflow = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= FULL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign nonzero = (count_q != '0);

endmodule

// File: rtl/dispatch_scheduler.sv
// rtl/dispatch_scheduler.sv - one-entry micro-op dispatcher with RS/ROB credits
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   flush                         synchronous pipeline flush, highest priority
//   in_valid/in_ready/in_uop      decoder handshake
//   alu_valid/br_valid/lsu_valid  dispatch strobes, one per RS group
//   out_uop/out_tag               held micro-op and its ROB tag
//   alu_free/br_free/lsu_free     RS entry released (one credit each)
//   rob_retire                    one ROB entry retired
//   illegal                       pulse: FU_ILL micro-op dropped
//   credit_err                    sticky: credit returned to a full counter
//   stall_cnt                     saturating count of held-but-blocked cycles
module dispatch_scheduler
    import sched_pkg::*;
#(
    parameter int ALU_RS_DEPTH = ALU_RS_DEPTH_DEF,
    parameter int BR_RS_DEPTH  = BR_RS_DEPTH_DEF,
    parameter int LSU_RS_DEPTH = LSU_RS_DEPTH_DEF,
    parameter int ROB_DEPTH    = ROB_DEPTH_DEF,
    localparam int TAG_W       = $clog2(ROB_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  uop_t             in_uop,
    output logic             alu_valid,
    output logic             br_valid,
    output logic             lsu_valid,
    output uop_t             out_uop,
    output logic [TAG_W-1:0] out_tag,
    input  logic             alu_free,
    input  logic             br_free,
    input  logic             lsu_free,
    input  logic             rob_retire,
    output logic             illegal,
    output logic             credit_err,
    output logic [15:0]      stall_cnt
);

    logic             hv_q, hv_d;
    uop_t             huop_q, huop_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic             credit_err_q, credit_err_d;
    logic [15:0]      stall_cnt_q, stall_cnt_d;

    logic alu_nz, br_nz, lsu_nz, rob_nz;
    logic alu_ovf, br_ovf, lsu_ovf, rob_ovf;
    logic [$clog2(ALU_RS_DEPTH+1)-1:0] alu_cnt;
    logic [$clog2(BR_RS_DEPTH+1)-1:0]  br_cnt;
    logic [$clog2(LSU_RS_DEPTH+1)-1:0] lsu_cnt;
    logic [$clog2(ROB_DEPTH+1)-1:0]    rob_cnt;
    logic unused_cnt;

    fu_type_e fu;
    logic     tgt_nz;
    logic     fire;

    assign fu = huop_q.fu_type;
    assign unused_cnt = ^{alu_cnt, br_cnt, lsu_cnt, rob_cnt};

    always_comb begin
        tgt_nz = 1'b0;
        case (fu)
            FU_ALU:  tgt_nz = alu_nz;
            FU_BR:   tgt_nz = br_nz;
            FU_LSU:  tgt_nz = lsu_nz;
            default: tgt_nz = 1'b0;
        endcase
    end

    assign fire      = hv_q && !flush && tgt_nz && rob_nz && (fu != FU_ILL);
    assign alu_valid = fire && (fu == FU_ALU);
    assign br_valid  = fire && (fu == FU_BR);
    assign lsu_valid = fire && (fu == FU_LSU);
    assign illegal   = hv_q && !flush && (fu == FU_ILL);
    // A dropped illegal op frees the slot this cycle just like a dispatch.
    assign in_ready  = !flush && (!hv_q || fire || illegal);

    assign out_uop    = huop_q;
    assign out_tag    = tail_q;
    assign credit_err = credit_err_q;
    assign stall_cnt  = stall_cnt_q;

    always_comb begin
        hv_d         = hv_q;
        huop_d       = huop_q;
        tail_d       = tail_q;
        credit_err_d = credit_err_q | alu_ovf | br_ovf | lsu_ovf | rob_ovf;
        stall_cnt_d  = stall_cnt_q;
        if (flush) begin
            hv_d   = 1'b0;
            tail_d = '0;
        end else begin
            if (fire || illegal) begin
                hv_d = 1'b0;
            end
            if (in_valid && in_ready) begin
                hv_d   = 1'b1;
                huop_d = in_uop;
            end
            if (fire) begin
                tail_d = tail_q + 1'b1;
            end
        end
        if (hv_q && !fire && !flush && (fu != FU_ILL) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hv_q         <= 1'b0;
            huop_q       <= '0;
            tail_q       <= '0;
            credit_err_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            hv_q         <= hv_d;
            huop_q       <= huop_d;
            tail_q       <= tail_d;
            credit_err_q <= credit_err_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    credit_counter #(.DEPTH(ALU_RS_DEPTH)) u_alu_cred (
        .clk(clk), .rst_n(rst_n), .consume(alu_valid), .ret(alu_free), .reload(flush),
        .count(alu_cnt), .nonzero(alu_nz), .overflow(alu_ovf)
    );

    credit_counter #(.DEPTH(BR_RS_DEPTH)) u_br_cred (
        .clk(clk), .rst_n(rst_n), .consume(br_valid), .ret(br_free), .reload(flush),
        .count(br_cnt), .nonzero(br_nz), .overflow(br_ovf)
    );

    credit_counter #(.DEPTH(LSU_RS_DEPTH)) u_lsu_cred (
        .clk(clk), .rst_n(rst_n), .consume(lsu_valid), .ret(lsu_free), .reload(flush),
        .count(lsu_cnt), .nonzero(lsu_nz), .overflow(lsu_ovf)
    );

    credit_counter #(.DEPTH(ROB_DEPTH)) u_rob_cred (
        .clk(clk), .rst_n(rst_n), .consume(fire), .ret(rob_retire), .reload(flush),
        .count(rob_cnt), .nonzero(rob_nz), .overflow(rob_ovf)
    );

endmodule

// File: tb/tb_dispatch_scheduler.sv
// tb/tb_dispatch_scheduler.sv - self-checking bench for dispatch_scheduler
module tb_dispatch_scheduler;
    import sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    uop_t        in_uop = '0;
    logic        alu_valid, br_valid, lsu_valid;
    uop_t        out_uop;
    logic [3:0]  out_tag;
    logic        alu_free = 1'b0, br_free = 1'b0, lsu_free = 1'b0, rob_retire = 1'b0;
    logic        illegal, credit_err;
    logic [15:0] stall_cnt;

    typedef struct {
        logic [1:0] fu;
        logic [8:0] pc;
        logic [3:0] tag;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] exp_tag = '0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         fires = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dispatch_scheduler dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_uop(in_uop),
        .alu_valid(alu_valid), .br_valid(br_valid), .lsu_valid(lsu_valid),
        .out_uop(out_uop), .out_tag(out_tag),
        .alu_free(alu_free), .br_free(br_free), .lsu_free(lsu_free),
        .rob_retire(rob_retire), .illegal(illegal), .credit_err(credit_err),
        .stall_cnt(stall_cnt)
    );

    // Scoreboard: every strobe must match the oldest expected dispatch.
    always @(negedge clk) begin
        exp_t       e;
        logic [2:0] got;
        logic [2:0] want;
        if (rst_n && (alu_valid || br_valid || lsu_valid)) begin
            fires++;
            n_tests++;
            got = {lsu_valid, br_valid, alu_valid};
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL dispatch_unexpected strobes=%b tag=%0d pc=%0d", got, out_tag, out_uop.pc);
            end else begin
                e    = exp_q.pop_front();
                want = 3'b001 << e.fu;
                if (got !== want || out_tag !== e.tag || out_uop.pc !== e.pc) begin
                    n_fail++;
                    $display("FAIL dispatch strobes=%b tag=%0d pc=%0d, expected strobes=%b tag=%0d pc=%0d",
                             got, out_tag, out_uop.pc, want, e.tag, e.pc);
                end
            end
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
        alu_free = 1'b0; br_free = 1'b0; lsu_free = 1'b0; rob_retire = 1'b0;
        exp_q.delete();
        exp_tag = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one micro-op and returns 1 ns after the edge that accepts it.
    task automatic send(input logic [1:0] fu, input logic [8:0] pc, input bit push);
        bit ok = 1'b0;
        if (push) begin
            exp_q.push_back('{fu, pc, exp_tag});
            exp_tag = exp_tag + 4'd1;
        end
        in_uop         = '0;
        in_uop.fu_type = fu_type_e'(fu);
        in_uop.pc      = pc;
        in_uop.imm     = {23'd0, pc};
        in_valid       = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            step();
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout pc=%0d in_ready stayed 0, expected accept", pc);
            in_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_tests++;
        if ({alu_valid, br_valid, lsu_valid, illegal} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_strobes got=%b exp=0000", {alu_valid, br_valid, lsu_valid, illegal});
        end
        n_tests++;
        if (credit_err !== 1'b0 || stall_cnt !== 16'd0 || out_tag !== 4'd0) begin
            n_fail++; $display("FAIL reset_state err=%b stall=%0d tag=%0d exp 0/0/0", credit_err, stall_cnt, out_tag);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int start;
        apply_reset();
        start = cyc;
        for (int i = 0; i < 9; i++) send(FU_ALU, 9'(16 + i), 1'b1);
        in_valid = 1'b0;
        n_tests++;
        if (cyc - start !== 9) begin n_fail++; $display("FAIL b2b_cycles got=%0d exp=9", cyc - start); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (in_ready !== 1'b0 || alu_valid !== 1'b0 || stall_cnt !== 16'(k)) begin
                n_fail++;
                $display("FAIL b2b_stall ready=%b alu=%b stall=%0d exp 0/0/%0d", in_ready, alu_valid, stall_cnt, k);
            end
            step();
        end
        n_tests++;
        if (fires !== 0 && exp_q.size() !== 1) begin n_fail++; $display("FAIL b2b_pending got=%0d exp=1", exp_q.size()); end
        alu_free = 1'b1;
        @(negedge clk);
        n_tests++;
        if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_free_bypass alu=%b exp=0", alu_valid); end
        step();
        alu_free = 1'b0;
        @(negedge clk);
        n_tests++;
        if (alu_valid !== 1'b1 || stall_cnt !== 16'd4) begin
            n_fail++; $display("FAIL b2b_release alu=%b stall=%0d exp 1/4", alu_valid, stall_cnt);
        end
        step();
    endtask

    task automatic test_branch_credit();
        apply_reset();
        for (int i = 0; i < 5; i++) send(FU_BR, 9'(32 + i), 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (br_valid !== 1'b0) begin n_fail++; $display("FAIL br_full br=%b exp=0", br_valid); end
        step();
        br_free = 1'b1;
        @(negedge clk);
        n_tests++;
        if (br_valid !== 1'b0) begin n_fail++; $display("FAIL br_same_cycle br=%b exp=0", br_valid); end
        step();
        br_free = 1'b0;
        @(negedge clk);
        n_tests++;
        if (br_valid !== 1'b1 || out_tag !== 4'd4) begin
            n_fail++; $display("FAIL br_next_cycle br=%b tag=%0d exp 1/4", br_valid, out_tag);
        end
        step();
    endtask

    task automatic test_illegal();
        apply_reset();
        send(FU_ALU, 9'd100, 1'b1);
        send(FU_ILL, 9'd101, 1'b0);
        exp_q.push_back('{FU_ALU, 9'd102, exp_tag});
        exp_tag        = exp_tag + 4'd1;
        in_uop         = '0;
        in_uop.fu_type = FU_ALU;
        in_uop.pc      = 9'd102;
        @(negedge clk);
        n_tests++;
        if (illegal !== 1'b1 || {alu_valid, br_valid, lsu_valid} !== 3'b000) begin
            n_fail++; $display("FAIL ill_pulse ill=%b strobes=%b exp 1/000", illegal, {alu_valid, br_valid, lsu_valid});
        end
        n_tests++;
        if (in_ready !== 1'b1 || out_tag !== 4'd1 || stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL ill_state ready=%b tag=%0d stall=%0d exp 1/1/0", in_ready, out_tag, stall_cnt);
        end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (illegal !== 1'b0 || alu_valid !== 1'b1) begin
            n_fail++; $display("FAIL ill_next ill=%b alu=%b exp 0/1", illegal, alu_valid);
        end
        step();
    endtask

    task automatic test_credit_err();
        apply_reset();
        alu_free = 1'b1;
        @(negedge clk);
        n_tests++;
        if (credit_err !== 1'b0) begin n_fail++; $display("FAIL cerr_early got=%b exp=0", credit_err); end
        step();
        alu_free = 1'b0;
        @(negedge clk);
        n_tests++;
        if (credit_err !== 1'b1) begin n_fail++; $display("FAIL cerr_set got=%b exp=1", credit_err); end
        step();
        for (int i = 0; i < 9; i++) send(FU_ALU, 9'(300 + i), 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (alu_valid !== 1'b0 || in_ready !== 1'b0 || credit_err !== 1'b1) begin
            n_fail++; $display("FAIL cerr_saturate alu=%b ready=%b err=%b exp 0/0/1", alu_valid, in_ready, credit_err);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (credit_err !== 1'b0 || out_tag !== 4'd0 || in_ready !== 1'b1 || stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL async_reset err=%b tag=%0d ready=%b stall=%0d exp 0/0/1/0",
                               credit_err, out_tag, in_ready, stall_cnt);
        end
        exp_q.delete();
        exp_tag = '0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_flush();
        int start;
        apply_reset();
        for (int i = 0; i < 3; i++) send(FU_LSU, 9'(150 + i), 1'b1);
        for (int i = 0; i < 5; i++) send(FU_BR, 9'(160 + i), 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (br_valid !== 1'b0) begin n_fail++; $display("FAIL flush_prestall br=%b exp=0", br_valid); end
        step();
        flush    = 1'b1;
        lsu_free = 1'b1;
        void'(exp_q.pop_back());
        exp_tag  = '0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0 || {alu_valid, br_valid, lsu_valid} !== 3'b000) begin
            n_fail++; $display("FAIL flush_cycle ready=%b strobes=%b exp 0/000", in_ready, {alu_valid, br_valid, lsu_valid});
        end
        step();
        flush    = 1'b0;
        lsu_free = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || out_tag !== 4'd0 || br_valid !== 1'b0 || credit_err !== 1'b0) begin
            n_fail++; $display("FAIL flush_after ready=%b tag=%0d br=%b err=%b exp 1/0/0/0",
                               in_ready, out_tag, br_valid, credit_err);
        end
        step();
        start = cyc;
        for (int i = 0; i < 9; i++) send(FU_LSU, 9'(200 + i), 1'b1);
        in_valid = 1'b0;
        n_tests++;
        if (cyc - start !== 9) begin n_fail++; $display("FAIL flush_lsu_cycles got=%0d exp=9", cyc - start); end
        @(negedge clk);
        n_tests++;
        if (lsu_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_lsu_reload lsu=%b ready=%b exp 0/0", lsu_valid, in_ready);
        end
        step();
    endtask

    task automatic test_rob_wrap();
        logic [1:0] fu;
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            if (i == 16)         fu = FU_LSU;
            else if (i % 4 == 3) fu = FU_BR;
            else if (i % 2 == 0) fu = FU_ALU;
            else                 fu = FU_LSU;
            send(fu, 9'(64 + i), 1'b1);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_tests++;
            if (lsu_valid !== 1'b0 || in_ready !== 1'b0 || stall_cnt !== 16'(k)) begin
                n_fail++; $display("FAIL rob_stall lsu=%b ready=%b stall=%0d exp 0/0/%0d", lsu_valid, in_ready, stall_cnt, k);
            end
            step();
        end
        rob_retire = 1'b1;
        @(negedge clk);
        n_tests++;
        if (lsu_valid !== 1'b0) begin n_fail++; $display("FAIL rob_same_cycle lsu=%b exp=0", lsu_valid); end
        step();
        rob_retire = 1'b0;
        @(negedge clk);
        n_tests++;
        if (lsu_valid !== 1'b1 || out_tag !== 4'd0) begin
            n_fail++; $display("FAIL rob_wrap lsu=%b tag=%0d exp 1/0", lsu_valid, out_tag);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_branch_credit();
        test_illegal();
        test_credit_err();
        test_flush();
        test_rob_wrap();
        repeat (3) step();
        n_tests++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL drain pending=%0d exp=0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
